// File: rtl/btb_update_ctrl.sv
// btb_update_ctrl: collects resolved-branch target updates from two ports
// into a small circular FIFO and drains one entry per cycle into the BTB
// write port. A squash drops everything pending and incoming.

`ifndef XLEN
`define XLEN 32
`endif

module btb_update_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         upd0_valid,
  input  logic [`XLEN-1:0]             upd0_src_pc,
  input  logic [`XLEN-1:0]             upd0_dest_pc,
  input  logic                         upd1_valid,
  input  logic [`XLEN-1:0]             upd1_src_pc,
  input  logic [`XLEN-1:0]             upd1_dest_pc,
  output logic                         upd_ready,
  input  logic                         squash,
  output logic                         btb_write_enable,
  output logic [`XLEN-1:0]             btb_write_source_pc,
  output logic [`XLEN-1:0]             btb_write_dest_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [`XLEN-1:0] mem_src [DEPTH];
  logic [`XLEN-1:0] mem_dst [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] wr1_idx;
  logic             acc0;
  logic             acc1;
  logic             coalesce;
  logic             wr0;
  logic             wr1;
  logic             deq;
  logic [1:0]       enq_num;

  // Ready looks only at the registered count: a same-cycle dequeue is not
  // credited, so two free slots are always guaranteed when ready is high.
  assign upd_ready = (count <= CNT_W'(DEPTH - 2));

  assign acc0     = upd0_valid & upd_ready & ~squash;
  assign acc1     = upd1_valid & upd_ready & ~squash;
  // Same branch reported twice in one cycle: the younger target wins and
  // only one entry is spent on it.
  assign coalesce = acc0 & acc1 & (upd0_src_pc == upd1_src_pc);
  assign wr0      = acc0 & ~coalesce;
  assign wr1      = acc1;
  // Port 1 lands right behind port 0 when both are written; the pointer
  // width gives the modulo-DEPTH wrap for free.
  assign wr1_idx  = tail + PTR_W'(wr0);
  assign enq_num  = {1'b0, wr0} + {1'b0, wr1};

  // The BTB never stalls, so any occupied head is consumed this cycle.
  assign deq      = (count != '0);

  assign btb_write_enable    = deq;
  assign btb_write_source_pc = deq ? mem_src[head] : '0;
  assign btb_write_dest_pc   = deq ? mem_dst[head] : '0;

  // Entry storage: written on accept, never reset (validity lives in count).
  always_ff @(posedge clock) begin
    if (wr0) begin
      mem_src[tail] <= upd0_src_pc;
      mem_dst[tail] <= upd0_dest_pc;
    end
    if (wr1) begin
      mem_src[wr1_idx] <= upd1_src_pc;
      mem_dst[wr1_idx] <= upd1_dest_pc;
    end
  end

  // Pointers and occupancy; reset outranks squash, squash empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(deq);
      tail  <= tail + PTR_W'(enq_num);
      count <= count + CNT_W'(enq_num) - CNT_W'(deq);
    end
  end

endmodule
